imem_hex_loader: RTL

//   Operator-driven writer for the processor instruction memory. Collects four hex nibbles from

---
 rtl/imem_hex_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/imem_hex_loader.sv
// Operator-driven instruction-memory writer: collects hex nibbles MSB-first from switch strobes
// and writes each assembled word to consecutive addresses over a valid/ready port.
module imem_hex_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              Reset_n,
    input  logic              load_en,
    input  logic [3:0]        nib_in,
    input  logic              nib_strobe,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] entry_word,
    output logic [1:0]        nib_cnt,
    output logic              busy,
    output logic              done_pulse,
    output logic              wrapped,
    output logic              dropped,
    output logic [1:0]        dbg_state
);

    localparam int         NIBS     = DATA_W / 4;
    localparam logic [1:0] LAST_NIB = 2'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_next;

    logic              start_load;
    logic              abort_entry;
    logic              take_nib;
    logic              last_nib;
    logic              accept;
    logic [DATA_W-1:0] shifted;

    // Write port handshake: a beat transfers on any rising edge where wr_en && wr_ready;
    // wr_en, wr_addr and wr_data hold steady from the first WRITE cycle until that edge.
    assign wr_en     = (state == WRITE);
    assign busy      = (state != IDLE);
    assign wr_addr   = cur_addr;
    assign dbg_state = state;

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_load  = 1'b0;
        abort_entry = 1'b0;
        take_nib    = 1'b0;
        last_nib    = 1'b0;
        accept      = 1'b0;
        shifted     = {entry_word[DATA_W-5:0], nib_in};
        case (state)
            IDLE: begin
                if (load_en) begin
                    start_load = 1'b1;
                    state_next = ENTER;
                end
            end
            ENTER: begin
                // Dropping load_en takes priority over a same-cycle strobe.
                if (!load_en) begin
                    abort_entry = 1'b1;
                    state_next  = IDLE;
                end else if (nib_strobe) begin
                    take_nib = 1'b1;
                    if (nib_cnt == LAST_NIB) begin
                        last_nib   = 1'b1;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    accept     = 1'b1;
                    state_next = load_en ? ENTER : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_addr   <= '0;
            entry_word <= '0;
            wr_data    <= '0;
            nib_cnt    <= '0;
            done_pulse <= 1'b0;
            wrapped    <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            done_pulse <= accept;
            if (start_load) begin
                cur_addr   <= '0;
                entry_word <= '0;
                nib_cnt    <= '0;
                wrapped    <= 1'b0;
                dropped    <= 1'b0;
            end
            if (abort_entry) begin
                entry_word <= '0;
                nib_cnt    <= '0;
            end
            if (take_nib) begin
                entry_word <= shifted;
                nib_cnt    <= last_nib ? 2'd0 : nib_cnt + 2'd1;
            end
            if (last_nib) wr_data <= shifted;
            if (state == WRITE && nib_strobe) dropped <= 1'b1;
            if (accept) begin
                cur_addr   <= cur_addr + 1'b1;
                entry_word <= '0;
                if (cur_addr == '1) wrapped <= 1'b1;
            end
        end
    end

endmodule
